// File: rtl/spi_slave_top_if.sv
// Host-side bus of the SPI slave: FIFO access, mode control and status.
interface spi_slave_top_if;
    logic       irq_en;
    logic       spi_en;
    logic       wr_txfifo;
    logic       rd_rxfifo;
    logic [7:0] wrdata;
    logic       cpol;
    logic       cpha;
    logic       firstbit;
    logic [7:0] rddata;
    logic       tr_flag;
    logic       txfifo_full;
    logic       rxfifo_empty;
    logic       busy;
    logic       ovr_err;
    logic       udr_err;
    logic       irq;

    modport master (
        output irq_en, spi_en, wr_txfifo, rd_rxfifo, wrdata,
        output cpol, cpha, firstbit,
        input  rddata, tr_flag, txfifo_full, rxfifo_empty,
        input  busy, ovr_err, udr_err, irq
    );

    modport slave (
        input  irq_en, spi_en, wr_txfifo, rd_rxfifo, wrdata,
        input  cpol, cpha, firstbit,
        output rddata, tr_flag, txfifo_full, rxfifo_empty,
        output busy, ovr_err, udr_err, irq
    );
endinterface

// File: rtl/spi_slave_top.sv
// Oversampled SPI slave with TX/RX byte FIFOs.
// Define SPI_SLAVE_ERR_EN to enable sticky overrun/underrun flags.
module spi_slave_top #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_top_if.slave  bus,
    input  logic            SCK,
    input  logic            MOSI,
    input  logic            CS_N,
    output logic            MISO,
    output logic            MISO_OE
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // [0],[1] synchroniser, [2] history
    logic [2:0] sck_q, mosi_q, csn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= 3'b000;
            mosi_q <= 3'b000;
            csn_q  <= 3'b111;
        end else begin
            sck_q  <= {sck_q[1:0], SCK};
            mosi_q <= {mosi_q[1:0], MOSI};
            csn_q  <= {csn_q[1:0], CS_N};
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise;
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~csn_q[1] & csn_q[2];
    assign cs_rise  = csn_q[1] & ~csn_q[2];

    state_t     state_q;
    logic       cpol_q, cpha_q, lsb_q;
    logic [7:0] tx_sh_q, rx_sh_q, rx_byte_q;
    logic [2:0] bit_cnt_q;
    logic       first_q, reload_q;
    logic       miso_q, oe_q, rx_wr_q, tr_q;

    logic       lead, trail, abort, shifting, sample, present, tx_pop;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0] tx_byte, tx_shift, rx_next;

    ptr_t tx_wr_q, tx_rd_q, rx_wr_q_ptr, rx_rd_q;
    cnt_t tx_cnt_q, rx_cnt_q;
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [7:0] rddata_q;

    assign lead     = cpol_q ? sck_fall : sck_rise;
    assign trail    = cpol_q ? sck_rise : sck_fall;
    assign abort    = ~bus.spi_en | cs_rise;
    assign shifting = (state_q == SHIFT) & ~abort;
    assign sample   = shifting & (cpha_q ? trail : lead);
    assign present  = shifting & (cpha_q ? lead : trail);
    assign tx_pop   = (state_q == LOAD) | (present & reload_q);

    assign tx_byte  = tx_empty ? FILL_BYTE : tx_mem[tx_rd_q];
    assign tx_shift = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    assign rx_next  = lsb_q ? {mosi_q[2], rx_sh_q[7:1]}
                            : {rx_sh_q[6:0], mosi_q[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_byte_q <= 8'h00;
            bit_cnt_q <= 3'd0;
            first_q   <= 1'b0;
            reload_q  <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            rx_wr_q   <= 1'b0;
            tr_q      <= 1'b0;
        end else begin
            rx_wr_q <= 1'b0;
            tr_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    oe_q   <= 1'b0;
                    miso_q <= 1'b0;
                    if (bus.spi_en && cs_fall) begin
                        cpol_q  <= bus.cpol;
                        cpha_q  <= bus.cpha;
                        lsb_q   <= bus.firstbit;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    tx_sh_q   <= tx_byte;
                    miso_q    <= lsb_q ? tx_byte[0] : tx_byte[7];
                    oe_q      <= 1'b1;
                    bit_cnt_q <= 3'd0;
                    first_q   <= 1'b1;
                    reload_q  <= 1'b0;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    if (abort) begin
                        oe_q      <= 1'b0;
                        bit_cnt_q <= 3'd0;
                        reload_q  <= 1'b0;
                        first_q   <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        if (sample) begin
                            rx_sh_q   <= rx_next;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_wr_q   <= 1'b1;
                                rx_byte_q <= rx_next;
                                tr_q      <= 1'b1;
                                reload_q  <= 1'b1;
                                bit_cnt_q <= 3'd0;
                            end
                        end
                        if (present) begin
                            first_q <= 1'b0;
                        end
                        // cpha=1: first leading edge only confirms bit already on MISO
                        if (present && !(cpha_q && first_q)) begin
                            if (reload_q) begin
                                tx_sh_q  <= tx_byte;
                                miso_q   <= lsb_q ? tx_byte[0] : tx_byte[7];
                                reload_q <= 1'b0;
                            end else begin
                                tx_sh_q <= tx_shift;
                                miso_q  <= lsb_q ? tx_sh_q[1] : tx_sh_q[6];
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic tx_push, tx_do_pop, rx_push, rx_pop;
    assign tx_empty  = (tx_cnt_q == '0);
    assign tx_full   = (tx_cnt_q == cnt_t'(FIFO_DEPTH));
    assign rx_empty  = (rx_cnt_q == '0);
    assign rx_full   = (rx_cnt_q == cnt_t'(FIFO_DEPTH));
    assign tx_push   = bus.wr_txfifo & ~tx_full;
    assign tx_do_pop = tx_pop & ~tx_empty;
    assign rx_push   = rx_wr_q & ~rx_full;
    assign rx_pop    = bus.rd_rxfifo & ~rx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wr_q_ptr <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            rddata_q    <= 8'h00;
        end else begin
            if (tx_push)   tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_do_pop) tx_rd_q <= tx_rd_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_do_pop);
            if (rx_push) rx_wr_q_ptr <= rx_wr_q_ptr + 1'b1;
            if (rx_pop) begin
                rx_rd_q  <= rx_rd_q + 1'b1;
                rddata_q <= rx_mem[rx_rd_q];
            end
            rx_cnt_q <= rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= bus.wrdata;
        if (rx_push) rx_mem[rx_wr_q_ptr] <= rx_byte_q;
    end

`ifdef SPI_SLAVE_ERR_EN
    logic ovr_q, udr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else if (!bus.spi_en) begin
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            if (rx_wr_q && rx_full) ovr_q <= 1'b1;
            if (tx_pop && tx_empty) udr_q <= 1'b1;
        end
    end

    assign bus.ovr_err = ovr_q;
    assign bus.udr_err = udr_q;
`else
    assign bus.ovr_err = 1'b0;
    assign bus.udr_err = 1'b0;
`endif

    assign MISO             = miso_q;
    assign MISO_OE          = oe_q;
    assign bus.rddata       = rddata_q;
    assign bus.tr_flag      = tr_q;
    assign bus.irq          = bus.irq_en & tr_q;
    assign bus.txfifo_full  = tx_full;
    assign bus.rxfifo_empty = rx_empty;
    assign bus.busy         = ~csn_q[1] & bus.spi_en;
endmodule

// File: tb/tb_spi_slave_top.sv
// Directed bench for spi_slave_top: table of single-byte frames
// in every mode, plus multi-byte, underrun, overrun, abort and reset cases.
module tb_spi_slave_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SCK = 1'b0;
    logic MOSI = 1'b0;
    logic CS_N = 1'b1;
    logic MISO, MISO_OE;

    spi_slave_top_if bus();

    spi_slave_top #(.FIFO_DEPTH(8), .FILL_BYTE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N),
        .MISO(MISO), .MISO_OE(MISO_OE)
    );

    always #5 clk = ~clk;

`ifdef SPI_SLAVE_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    localparam int HALF = 80;

    int checks = 0;
    int errors = 0;
    int tr_cnt = 0;
    int irq_cnt = 0;
    logic m_cpol, m_cpha, m_lsb;

    always @(negedge clk) begin
        if (bus.tr_flag) tr_cnt++;
        if (bus.irq) irq_cnt++;
    end

    typedef struct {
        logic       cpol, cpha, lsb;
        logic [7:0] tx, mosi;
        logic [7:0] exp_miso, exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_mode(input logic c, input logic p, input logic l);
        bus.cpol = c; bus.cpha = p; bus.firstbit = l;
        m_cpol = c; m_cpha = p; m_lsb = l;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        bus.wr_txfifo = 1'b1;
        bus.wrdata = d;
        @(negedge clk);
        bus.wr_txfifo = 1'b0;
    endtask

    task automatic pop(output logic [7:0] d);
        @(negedge clk);
        bus.rd_rxfifo = 1'b1;
        @(negedge clk);
        bus.rd_rxfifo = 1'b0;
        d = bus.rddata;
    endtask

    task automatic frame_begin();
        SCK = m_cpol;
        #100;
        CS_N = 1'b0;
        #100;
    endtask

    task automatic frame_end();
        #HALF;
        CS_N = 1'b1;
        #100;
    endtask

    task automatic xbit(input logic b, output logic r);
        if (!m_cpha) begin
            MOSI = b;
            #HALF;
            r = MISO;
            SCK = ~m_cpol;
            #HALF;
            SCK = m_cpol;
        end else begin
            SCK = ~m_cpol;
            MOSI = b;
            #HALF;
            r = MISO;
            SCK = m_cpol;
            #HALF;
        end
    endtask

    task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 0; i < 8; i++) begin
            int b;
            b = m_lsb ? i : 7 - i;
            xbit(tx[b], r);
            rx[b] = r;
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.spi_en = 1'b0;
        repeat (3) @(negedge clk);
        bus.spi_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t       vt[7];
        logic [7:0] got, rd;
        logic       r;
        int         t0, i0;

        vt[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vt[1] = '{1'b0, 1'b1, 1'b0, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
        vt[2] = '{1'b1, 1'b0, 1'b0, 8'h0F, 8'hE7, 8'h0F, 8'hE7};
        vt[3] = '{1'b1, 1'b1, 1'b0, 8'h96, 8'h69, 8'h96, 8'h69};
        vt[4] = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 8'h12, 8'h34};
        vt[5] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01};
        vt[6] = '{1'b0, 1'b1, 1'b1, 8'h7E, 8'h81, 8'h7E, 8'h81};

        bus.irq_en = 1'b1;
        bus.spi_en = 1'b1;
        bus.wr_txfifo = 1'b0;
        bus.rd_rxfifo = 1'b0;
        bus.wrdata = 8'h00;
        set_mode(1'b0, 1'b0, 1'b0);

        #20;
        chk("rst_miso", MISO, 1'b0);
        chk("rst_oe", MISO_OE, 1'b0);
        chk("rst_rddata", bus.rddata, 8'h00);
        chk("rst_tr", bus.tr_flag, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_full", bus.txfifo_full, 1'b0);
        chk("rst_empty", bus.rxfifo_empty, 1'b1);
        chk("rst_errs", {bus.ovr_err, bus.udr_err, bus.irq}, 3'b000);
        #30;
        rst_n = 1'b1;
        #100;

        for (int k = 0; k < 7; k++) begin
            set_mode(vt[k].cpol, vt[k].cpha, vt[k].lsb);
            push(vt[k].tx);
            t0 = tr_cnt;
            i0 = irq_cnt;
            frame_begin();
            chk($sformatf("v%0d_busy", k), bus.busy, 1'b1);
            xbyte(vt[k].mosi, got);
            frame_end();
            chk($sformatf("v%0d_miso", k), got, vt[k].exp_miso);
            chk($sformatf("v%0d_tr", k), tr_cnt - t0, 1);
            chk($sformatf("v%0d_irq", k), irq_cnt - i0, 1);
            pop(rd);
            chk($sformatf("v%0d_rd", k), rd, vt[k].exp_rd);
            chk($sformatf("v%0d_empty", k), bus.rxfifo_empty, 1'b1);
        end

        set_mode(1'b1, 1'b1, 1'b1);
        push(8'h01); push(8'h02); push(8'h03);
        t0 = tr_cnt;
        frame_begin();
        xbyte(8'h10, got); chk("m3_miso0", got, 8'h01);
        xbyte(8'h20, got); chk("m3_miso1", got, 8'h02);
        xbyte(8'h30, got); chk("m3_miso2", got, 8'h03);
        frame_end();
        chk("m3_tr", tr_cnt - t0, 3);
        pop(rd); chk("m3_rd0", rd, 8'h10);
        pop(rd); chk("m3_rd1", rd, 8'h20);
        pop(rd); chk("m3_rd2", rd, 8'h30);

        set_mode(1'b0, 1'b0, 1'b0);
        clear_err();
        chk("udr_clear", bus.udr_err, 1'b0);
        push(8'h55);
        frame_begin();
        xbyte(8'h11, got); chk("udr_miso0", got, 8'h55);
        xbyte(8'h22, got); chk("udr_miso1", got, 8'hFF);
        frame_end();
        chk("udr_flag", bus.udr_err, EXP_ERR);
        pop(rd); chk("udr_rd0", rd, 8'h11);
        pop(rd); chk("udr_rd1", rd, 8'h22);

        clear_err();
        chk("ovr_clear", bus.ovr_err, 1'b0);
        t0 = tr_cnt;
        frame_begin();
        for (int b = 0; b < 9; b++) xbyte(8'(b), got);
        frame_end();
        chk("ovr_tr", tr_cnt - t0, 9);
        chk("ovr_flag", bus.ovr_err, EXP_ERR);
        for (int b = 0; b < 8; b++) begin
            pop(rd);
            chk($sformatf("ovr_rd%0d", b), rd, 8'(b));
        end
        chk("ovr_empty", bus.rxfifo_empty, 1'b1);

        t0 = tr_cnt;
        frame_begin();
        for (int b = 0; b < 5; b++) xbit(1'b1, r);
        chk("abort_oe_on", MISO_OE, 1'b1);
        CS_N = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_oe_off", MISO_OE, 1'b0);
        #100;
        chk("abort_tr", tr_cnt - t0, 0);
        chk("abort_empty", bus.rxfifo_empty, 1'b1);
        frame_begin();
        xbyte(8'h81, got);
        frame_end();
        chk("abort_next_tr", tr_cnt - t0, 1);
        pop(rd);
        chk("abort_next_rd", rd, 8'h81);

        for (int b = 0; b < 8; b++) push(8'hC0 + 8'(b));
        chk("tx_full", bus.txfifo_full, 1'b1);
        frame_begin();
        for (int b = 0; b < 3; b++) xbit(1'b0, r);
        rst_n = 1'b0;
        #20;
        chk("mrst_miso", MISO, 1'b0);
        chk("mrst_oe", MISO_OE, 1'b0);
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_full", bus.txfifo_full, 1'b0);
        chk("mrst_empty", bus.rxfifo_empty, 1'b1);
        chk("mrst_tr", bus.tr_flag, 1'b0);
        chk("mrst_rddata", bus.rddata, 8'h00);
        chk("mrst_errs", {bus.ovr_err, bus.udr_err, bus.irq}, 3'b000);
        CS_N = 1'b1;
        SCK = 1'b0;
        #30;
        rst_n = 1'b1;
        #100;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
